uno_horner: RTL and testbench
=============================

UNO_HORNER -- requirements
Module: uno_horner

Interface
REQ-001 Parameter BW, default 12, operand width; signed fixed point with FRAC_BW fractional bits.
REQ-002 Parameter FRAC_BW, default 8, fractional bits; INT_BW = BW-FRAC_BW is derived, not a parameter.
REQ-003 Parameter TERMS, default 4, range 2..8, polynomial coefficient count per nonlinear op.
REQ-004 Ports, clock and reset first:
- clk  in  1  sole clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  request valid.
- in_ready  out  1  block can accept a request.
- op  in  2  00 MAC, 01 div, 10 exp, 11 log.
- acc_en  in  1  MAC accumulates onto the previous MAC result instead of Z.
- X, Y  in  BW each  operands.
- Z  in  2*BW  MAC addend.
- cfg_we  in  1  coefficient write strobe.
- cfg_op  in  2  target op, 01..11; 00 ignored.
- cfg_idx  in  clog2(TERMS)  coefficient index.
- cfg_data  in  BW  coefficient value.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_data  out  2*BW  result.
- out_err  out  1  domain error, qualified by out_valid.

Function
REQ-005 FSM states: IDLE, PREP, ITER, FINAL, DONE; in_ready = (state==IDLE).
REQ-006 Accept on in_valid && in_ready; latch op, acc_en, X, Y, Z.
REQ-007 MAC: IDLE->DONE; out_data = X*Y + (acc_en ? mac_acc : Z), signed, 2*BW wrap; mac_acc loads out_data; out_valid is high the cycle after acceptance.
REQ-008 Nonlinear op flow: IDLE->PREP->ITER (TERMS-1 cycles)->FINAL->DONE; out_valid rises TERMS+2 cycles after acceptance.
REQ-009 PREP: p = index of the leading one of X; e = p-(FRAC_BW-1); x_norm = X shifted so the leading one lands at bit FRAC_BW-1; acc = C[op][TERMS-1].
REQ-010 Variable v and scale/offset:
- div: v = 0.75 - x_norm; scale = Y arithmetic-shifted right by e (left by -e); offset = 0.
- exp: v = X[FRAC_BW-1:0] zero-extended; scale = EXP_TAB[X[BW-1:FRAC_BW] signed]; offset = 0.
- log: v = 0.75 - x_norm; scale = 1.0; offset = e*LN2 sign-extended to 2*BW.
REQ-011 ITER step k = TERMS-2 down to 0: acc = ((acc*v) >>> FRAC_BW) + C[op][k]; truncate to BW per REQ-020.
REQ-012 FINAL: out_data = ((acc*scale) >>> FRAC_BW) + offset, 2*BW signed.
REQ-013 Domain error: div or log with X <= 0 sets out_err = 1 and out_data = 0; FSM goes PREP->DONE, skipping ITER and FINAL.
REQ-014 DONE: out_valid = 1; out_data and out_err stay stable until out_ready; on out_ready, go to IDLE, with in_ready high the next cycle.
REQ-015 Coefficient writes:
- C[cfg_op][cfg_idx] is written on cfg_we only in IDLE, or in DONE for the op not in flight.
- Any other write is dropped.
- A write and an acceptance in the same IDLE cycle: the write lands first, and the new value is used.
REQ-016 Requests with in_valid while in_ready = 0 are not captured; the producer holds them.

Reset
REQ-017 On rst: state = IDLE; out_valid = 0; out_data = 0; out_err = 0; mac_acc = 0; all coefficients = 0; in_ready = 1 the first cycle after release.
REQ-018 rst asserted mid-operation aborts the operation; no out_valid is produced for it.

Configuration
REQ-019 Macro UNO_SAT_EN selects saturation in the ITER step.
REQ-020 With UNO_SAT_EN: each ITER result saturates to [-2^(BW-1), 2^(BW-1)-1]. Without it: two's-complement wrap to BW.

Structure
REQ-021 Package uno_pkg holds:
- the op enum;
- the FSM state enum;
- EXP_TAB (2^INT_BW entries, exp(i) in Q format, saturated);
- the LN2 constant;
- the 0.75 constant.
REQ-022 One sub-module, uno_norm: combinational leading-one detect, e, x_norm, and X<=0 flag; instantiated once.

Verification
REQ-023 MAC: X=3, Y=5, Z=7, acc_en=0 -> out_data = 22 one cycle after accept; then X=2, Y=2, acc_en=1 -> 26.
REQ-024 exp, TERMS=4:
- C = {256, 256, 128, 43}, X = 0 -> out_data = 256.
- out_valid rises exactly 6 cycles after accept.
REQ-025 div, X=0 -> out_err = 1, out_data = 0; log, X=0xF00 (negative) -> out_err = 1.
REQ-026 Backpressure: out_ready low 3 cycles in DONE -> out_data stable, in_ready = 0; a cfg write to the active op is dropped.
REQ-027 rst pulse during ITER -> state IDLE, out_valid = 0, coefficients read back 0; the next exp request returns 0.
REQ-028 Saturation: all C = 0x7FF, exp X = 0x0FF:
- with UNO_SAT_EN, each ITER acc = 0x7FF;
- without it, acc wraps and differs.

Source files
------------

// File: rtl/uno_pkg.sv
// uno_pkg -- shared types and constants for the uno_horner polynomial unit.
//
// Contents:
//   op_e      operation codes (MAC, divide, exp, log)
//   state_e   sequencer state encoding
//   Q075      0.75 in the Q format used by the unit
//   LN2_Q     ln(2) in the same Q format
//   EXP_TAB   exp(i) for every signed integer part i, saturated to the
//             largest positive operand value
//
// The constants are tabulated for the Q4.8 operand format, i.e. BW=12 and
// FRAC_BW=8. EXP_TAB is indexed by the raw two's-complement integer-part
// bits, so entries 0..7 hold exp(0..7) and entries 8..15 hold exp(-8..-1).
package uno_pkg;

    typedef enum logic [1:0] {
        OP_MAC = 2'b00,
        OP_DIV = 2'b01,
        OP_EXP = 2'b10,
        OP_LOG = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREP,
        ST_ITER,
        ST_FINAL,
        ST_DONE
    } state_e;

    localparam int Q_FRAC_BW = 8;
    localparam int Q_INT_BW  = 4;

    localparam int Q075  = 3 << (Q_FRAC_BW - 2);   // 0.75   -> 192
    localparam int LN2_Q = 177;                     // ln(2)  -> 177.4

    // exp(i) * 256, rounded; exp(3) and above saturate at 2047.
    localparam int EXP_TAB [2**Q_INT_BW] = '{
        256, 696, 1892, 2047, 2047, 2047, 2047, 2047,
        0,   0,   1,    2,    5,    13,   35,   94
    };

endpackage

// File: rtl/uno_norm.sv
// uno_norm -- combinational operand normaliser.
//
// Ports:
//   x_i       signed operand
//   e_o       exponent: (index of leading one) - (FRAC_BW-1)
//   x_norm_o  x_i shifted so the leading one sits at bit FRAC_BW-1
//   nonpos_o  x_i <= 0
//
// e_o and x_norm_o are meaningless when nonpos_o is set.
module uno_norm #(
    parameter int BW      = 12,
    parameter int FRAC_BW = 8,
    parameter int EW      = 6
) (
    input  logic signed [BW-1:0] x_i,
    output logic signed [EW-1:0] e_o,
    output logic        [BW-1:0] x_norm_o,
    output logic                 nonpos_o
);

    logic [EW-1:0] p;
    logic [BW-1:0] xu;

    assign xu       = x_i;
    assign nonpos_o = x_i[BW-1] || (x_i == '0);

    always_comb begin
        // Scan upward; the last hit is the leading one.
        p = '0;
        for (int i = 0; i < BW; i++) begin
            if (xu[i]) p = EW'(i);
        end
        e_o = $signed(p - EW'(FRAC_BW - 1));
        if (e_o[EW-1]) x_norm_o = xu << (-e_o);
        else           x_norm_o = xu >> e_o;
    end

endmodule

// File: rtl/uno_horner.sv
// uno_horner -- signed fixed-point MAC plus Horner-polynomial evaluator for
// divide, exp and log.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   in_valid / in_ready       request handshake; op, acc_en, X, Y, Z sampled
//                             when both are high
//   cfg_we, cfg_op, cfg_idx,  coefficient write port (C[cfg_op][cfg_idx])
//   cfg_data
//   out_valid / out_ready     result handshake; out_data and out_err hold
//                             while out_valid is high and out_ready is low
//   dbg_state                 current sequencer state
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; the producer keeps its payload steady until that edge.
//
// Build option: define UNO_SAT_EN to saturate every Horner step to BW bits
// instead of wrapping.
module uno_horner
    import uno_pkg::*;
#(
    parameter int BW      = 12,
    parameter int FRAC_BW = 8,
    parameter int TERMS   = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [1:0]                   op,
    input  logic                         acc_en,
    input  logic signed [BW-1:0]         X,
    input  logic signed [BW-1:0]         Y,
    input  logic signed [2*BW-1:0]       Z,
    input  logic                         cfg_we,
    input  logic [1:0]                   cfg_op,
    input  logic [$clog2(TERMS)-1:0]     cfg_idx,
    input  logic signed [BW-1:0]         cfg_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [2*BW-1:0]       out_data,
    output logic                         out_err,
    output state_e                       dbg_state
);

    localparam int W2 = 2 * BW;
    localparam int W3 = 3 * BW;
    localparam int IW = $clog2(TERMS);
    localparam int EW = $clog2(BW) + 2;

    state_e                state_q, state_d;
    op_e                   op_q;
    logic signed [BW-1:0]  x_q, y_q, acc_q, v_q;
    logic signed [W2-1:0]  scale_q, offset_q, out_data_q, mac_acc_q;
    logic                  out_err_q;
    logic [IW-1:0]         k_q;
    logic signed [BW-1:0]  coef_q [1:3][TERMS];

    logic signed [EW-1:0]  e;
    logic [BW-1:0]         x_norm;
    logic                  nonpos, dom_err;
    logic signed [BW-1:0]  v_d, acc_d, coef_k;
    logic signed [W2-1:0]  scale_d, offset_d, y_ext, mac_d, iter_sum, final_d;
    logic signed [W3-1:0]  fin_prod;
    logic                  cfg_ok;

    uno_norm #(.BW(BW), .FRAC_BW(FRAC_BW), .EW(EW)) u_norm (
        .x_i      (x_q),
        .e_o      (e),
        .x_norm_o (x_norm),
        .nonpos_o (nonpos)
    );

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign out_data  = out_data_q;
    assign out_err   = out_err_q;
    assign dbg_state = state_q;

    // MAC resolves in the accept cycle, straight from the request inputs.
    assign mac_d   = W2'(X) * W2'(Y) + (acc_en ? mac_acc_q : Z);
    assign dom_err = nonpos && (op_q == OP_DIV || op_q == OP_LOG);
    assign y_ext   = W2'(y_q);

    // Per-op Horner variable, result scale and additive offset.
    always_comb begin
        v_d      = '0;
        scale_d  = '0;
        offset_d = '0;
        case (op_q)
            OP_EXP: begin
                v_d[FRAC_BW-1:0] = x_q[FRAC_BW-1:0];
                scale_d          = W2'(EXP_TAB[x_q[BW-1:FRAC_BW]]);
            end
            OP_LOG: begin
                v_d      = BW'(Q075) - x_norm;
                scale_d  = W2'(1) << FRAC_BW;
                offset_d = W2'(e) * W2'(LN2_Q);
            end
            default: begin
                v_d     = BW'(Q075) - x_norm;
                scale_d = e[EW-1] ? (y_ext <<< (-e)) : (y_ext >>> e);
            end
        endcase
    end

    assign coef_k   = coef_q[op_q][k_q];
    assign iter_sum = ((W2'(acc_q) * W2'(v_q)) >>> FRAC_BW) + W2'(coef_k);

`ifdef UNO_SAT_EN
    // In range only when every bit from BW-1 upward matches the sign.
    always_comb begin
        if (&iter_sum[W2-1:BW-1] || ~|iter_sum[W2-1:BW-1]) acc_d = iter_sum[BW-1:0];
        else if (iter_sum[W2-1])                           acc_d = {1'b1, {(BW-1){1'b0}}};
        else                                               acc_d = {1'b0, {(BW-1){1'b1}}};
    end
`else
    assign acc_d = BW'(iter_sum);
`endif

    assign fin_prod = W3'(acc_q) * W3'(scale_q);
    assign final_d  = W2'(fin_prod >>> FRAC_BW) + offset_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (in_valid) state_d = (op_e'(op) == OP_MAC) ? ST_DONE : ST_PREP;
            ST_PREP:  state_d = dom_err ? ST_DONE : ST_ITER;
            ST_ITER:  if (k_q == '0) state_d = ST_FINAL;
            ST_FINAL: state_d = ST_DONE;
            ST_DONE:  if (out_ready) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q       <= OP_MAC;
            x_q        <= '0;
            y_q        <= '0;
            acc_q      <= '0;
            v_q        <= '0;
            scale_q    <= '0;
            offset_q   <= '0;
            out_data_q <= '0;
            mac_acc_q  <= '0;
            out_err_q  <= 1'b0;
            k_q        <= '0;
        end else begin
            case (state_q)
                ST_IDLE: if (in_valid) begin
                    x_q  <= X;
                    y_q  <= Y;
                    op_q <= op_e'(op);
                    if (op_e'(op) == OP_MAC) begin
                        out_data_q <= mac_d;
                        mac_acc_q  <= mac_d;
                        out_err_q  <= 1'b0;
                    end
                end
                ST_PREP: begin
                    acc_q     <= coef_q[op_q][TERMS-1];
                    v_q       <= v_d;
                    scale_q   <= scale_d;
                    offset_q  <= offset_d;
                    k_q       <= IW'(TERMS - 2);
                    out_err_q <= dom_err;
                    if (dom_err) out_data_q <= '0;
                end
                ST_ITER: begin
                    acc_q <= acc_d;
                    k_q   <= k_q - 1'b1;
                end
                ST_FINAL: out_data_q <= final_d;
                default: ;
            endcase
        end
    end

    // Coefficients may change only while they cannot disturb an operation:
    // in IDLE, or in DONE for an op other than the one just finished.
    assign cfg_ok = cfg_we && (cfg_op != 2'b00) && (32'(cfg_idx) < TERMS) &&
                    ((state_q == ST_IDLE) || ((state_q == ST_DONE) && (cfg_op != op_q)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int o = 1; o <= 3; o++) begin
                for (int k = 0; k < TERMS; k++) coef_q[o][k] <= '0;
            end
        end else if (cfg_ok) begin
            coef_q[cfg_op][cfg_idx] <= cfg_data;
        end
    end

endmodule

// File: tb/tb_uno_horner.sv
// tb_uno_horner -- directed-vector bench for uno_horner (BW=12, FRAC_BW=8,
// TERMS=4). Expected results are hand-derived Q4.8 values.
module tb_uno_horner;
    import uno_pkg::*;

    localparam int BW = 12;
    localparam int W2 = 24;

`ifdef UNO_SAT_EN
    localparam logic [W2-1:0] SAT_EXP = 24'h0007FF;
`else
    localparam logic [W2-1:0] SAT_EXP = 24'hFFFFEC;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid, in_ready, acc_en;
    logic [1:0]    op;
    logic [BW-1:0] X, Y;
    logic [W2-1:0] Z;
    logic          cfg_we;
    logic [1:0]    cfg_op, cfg_idx;
    logic [BW-1:0] cfg_data;
    logic          out_valid, out_ready, out_err;
    logic [W2-1:0] out_data;
    state_e        dbg_state;

    int n_chk = 0;
    int n_bad = 0;
    logic [W2:0] exp_q[$];

    uno_horner #(.BW(12), .FRAC_BW(8), .TERMS(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .acc_en    (acc_en),
        .X         (X),
        .Y         (Y),
        .Z         (Z),
        .cfg_we    (cfg_we),
        .cfg_op    (cfg_op),
        .cfg_idx   (cfg_idx),
        .cfg_data  (cfg_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_err   (out_err),
        .dbg_state (dbg_state)
    );

    // clock
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Called just after a falling edge; returns just after a falling edge.
    task automatic cfg(input logic [1:0] o, input logic [1:0] idx, input logic [BW-1:0] d);
        cfg_we = 1'b1; cfg_op = o; cfg_idx = idx; cfg_data = d;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    task automatic load4(input logic [1:0] o, input logic [BW-1:0] c0, c1, c2, c3);
        cfg(o, 2'd0, c0);
        cfg(o, 2'd1, c1);
        cfg(o, 2'd2, c2);
        cfg(o, 2'd3, c3);
    endtask

    // Issue one request, wait (bounded) for out_valid, score it. Any cfg write
    // set up by the caller lands in the same cycle as the acceptance.
    task automatic send(input string tag, input logic [1:0] o, input logic ae,
                        input logic [BW-1:0] x, input logic [BW-1:0] y, input logic [W2-1:0] z,
                        input logic [W2-1:0] ed, input logic ee, input int elat);
        int lat;
        logic [W2:0] e;
        exp_q.push_back({ee, ed});
        op = o; acc_en = ae; X = x; Y = y; Z = z; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        cfg_we   = 1'b0;
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        e = exp_q.pop_front();
        chk({tag, "_lat"}, lat, elat);
        chk({tag, "_data"}, out_data, e[W2-1:0]);
        chk({tag, "_err"}, out_err, e[W2]);
        if (out_ready) @(negedge clk);
    endtask

    initial begin
        int seen;
        rst = 1'b1; in_valid = 1'b0; acc_en = 1'b0; op = 2'b00;
        X = '0; Y = '0; Z = '0;
        cfg_we = 1'b0; cfg_op = 2'b00; cfg_idx = 2'd0; cfg_data = '0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // reset state
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_err", out_err, 0);
        chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));

        // MAC
        send("mac22", OP_MAC, 1'b0, 12'd3, 12'd5, 24'd7, 24'd22, 1'b0, 1);
        send("mac26", OP_MAC, 1'b1, 12'd2, 12'd2, 24'd0, 24'd26, 1'b0, 1);
        send("mac_neg", OP_MAC, 1'b0, 12'hFFD, 12'd5, 24'd0, 24'hFFFFF1, 1'b0, 1);
        send("mac_wrap", OP_MAC, 1'b0, 12'h800, 12'h800, 24'h7FFFFF, 24'hBFFFFF, 1'b0, 1);

        // exp: 1 + x + x^2/2 + x^3/6
        load4(OP_EXP, 12'd256, 12'd256, 12'd128, 12'd43);
        send("exp0", OP_EXP, 1'b0, 12'h000, 12'h0, 24'h0, 24'd256, 1'b0, 6);
        send("exp_half", OP_EXP, 1'b0, 12'h080, 12'h0, 24'h0, 24'd421, 1'b0, 6);
        send("exp1", OP_EXP, 1'b0, 12'h100, 12'h0, 24'h0, 24'd696, 1'b0, 6);
        send("exp_m1", OP_EXP, 1'b0, 12'hF00, 12'h0, 24'h0, 24'd94, 1'b0, 6);

        // div
        load4(OP_DIV, 12'd256, 12'd256, 12'd0, 12'd0);
        send("div1", OP_DIV, 1'b0, 12'h100, 12'h100, 24'h0, 24'd160, 1'b0, 6);
        send("div_small", OP_DIV, 1'b0, 12'h020, 12'h100, 24'h0, 24'd1280, 1'b0, 6);
        send("div_zero", OP_DIV, 1'b0, 12'h000, 12'h100, 24'h0, 24'd0, 1'b1, 2);

        // log
        load4(OP_LOG, 12'd0, 12'd256, 12'd0, 12'd0);
        send("log1", OP_LOG, 1'b0, 12'h100, 12'h0, 24'h0, 24'd241, 1'b0, 6);
        send("log_q", OP_LOG, 1'b0, 12'h040, 12'h0, 24'h0, 24'hFFFF8F, 1'b0, 6);
        send("log_vneg", OP_LOG, 1'b0, 12'h0E0, 12'h0, 24'h0, 24'hFFFFE0, 1'b0, 6);
        send("log_neg", OP_LOG, 1'b0, 12'hF00, 12'h0, 24'h0, 24'd0, 1'b1, 2);

        // backpressure in DONE; cfg to active op dropped, to another op kept
        out_ready = 1'b0;
        send("bp", OP_EXP, 1'b0, 12'h000, 12'h0, 24'h0, 24'd256, 1'b0, 6);
        cfg(OP_EXP, 2'd0, 12'd0);
        chk("bp_hold1", out_data, 24'd256);
        chk("bp_rdy1", in_ready, 0);
        cfg(OP_LOG, 2'd0, 12'd256);
        chk("bp_hold2", out_data, 24'd256);
        chk("bp_rdy2", in_ready, 0);
        @(negedge clk);
        chk("bp_hold3", out_data, 24'd256);
        chk("bp_valid3", out_valid, 1);
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_rdy", in_ready, 1);
        chk("bp_release_valid", out_valid, 0);
        send("bp_exp_kept", OP_EXP, 1'b0, 12'h000, 12'h0, 24'h0, 24'd256, 1'b0, 6);
        send("bp_log_written", OP_LOG, 1'b0, 12'h0C0, 12'h0, 24'h0, 24'd256, 1'b0, 6);

        // write and accept in the same IDLE cycle
        cfg_we = 1'b1; cfg_op = OP_EXP; cfg_idx = 2'd0; cfg_data = 12'd512;
        send("same_cycle", OP_EXP, 1'b0, 12'h000, 12'h0, 24'h0, 24'd512, 1'b0, 6);

        // saturation vs wrap
        load4(OP_EXP, 12'h7FF, 12'h7FF, 12'h7FF, 12'h7FF);
        send("sat", OP_EXP, 1'b0, 12'h0FF, 12'h0, 24'h0, SAT_EXP, 1'b0, 6);

        // reset during ITER
        op = OP_EXP; X = 12'h080; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        chk("abort_in_iter", 32'(dbg_state), 32'(ST_ITER));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_state", 32'(dbg_state), 32'(ST_IDLE));
        chk("abort_valid", out_valid, 0);
        chk("abort_rdy", in_ready, 1);
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("abort_no_valid", seen, 0);
        send("post_rst_exp", OP_EXP, 1'b0, 12'h000, 12'h0, 24'h0, 24'd0, 1'b0, 6);
        send("post_rst_mac", OP_MAC, 1'b1, 12'd1, 12'd1, 24'd99, 24'd1, 1'b0, 1);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
